// File: rtl/aes_key_expander_if.sv
// Request/stream bundle between a key-schedule consumer and aes_key_expander.
// The slave modport is the expander; the master modport issues start/key and accepts round keys.
// rk_valid/rk_ready form the round-key stream handshake; busy and done report progress.
interface aes_key_expander_if;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  rk_valid, rk_data, rk_round, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output rk_valid, rk_data, rk_round, busy, done
  );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: streams round keys 0..10 for one cipher key, one key per accepted beat.
// Latency: round 0 is valid the cycle after start is accepted; the next round is computed during each transfer.
// Backpressure: rk_data/rk_round hold while rk_ready is low; done pulses once the round-10 key is taken.
module aes_key_expander (
  input  logic                clk,
  input  logic                rst,
  aes_key_expander_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  // FIPS-197 forward S-box, entry 0x00 in the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table index for byte b is (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Rcon for the round being produced next (current round r -> Rcon[r+1]).
  function automatic logic [7:0] rcon_next(input logic [3:0] r);
    case (r)
      4'd0:    rcon_next = 8'h01;
      4'd1:    rcon_next = 8'h02;
      4'd2:    rcon_next = 8'h04;
      4'd3:    rcon_next = 8'h08;
      4'd4:    rcon_next = 8'h10;
      4'd5:    rcon_next = 8'h20;
      4'd6:    rcon_next = 8'h40;
      4'd7:    rcon_next = 8'h80;
      4'd8:    rcon_next = 8'h1b;
      4'd9:    rcon_next = 8'h36;
      default: rcon_next = 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic         xfer;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  // One S-box lookup per byte of the rotated last word.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_w[8*g +: 8] = sbox(rot_w[8*g +: 8]);
  end

  assign t_w = sub_w ^ {rcon_next(round_q), 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign xfer = (state_q == ST_EMIT) && bus.rk_ready;

  // Next-state logic: load on start in IDLE, advance one round per transfer in EMIT.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          round_d = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          if (round_q == 4'd10) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any stream without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_valid = (state_q == ST_EMIT);
  assign bus.busy     = (state_q == ST_EMIT);
  assign bus.rk_data  = key_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: vector table of known round keys plus hand-built stall/reset/restart sequences.
// Expected keys come from an independent model (S-box derived from GF(2^8) inverse + affine map).
// A scoreboard queue is filled when start is driven and drained on each observed transfer.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expander_if bus();

  aes_key_expander dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] expect_rk;
  } vec_t;

  exp_t         exp_q[$];
  logic [127:0] cap[11];
  logic [7:0]   sbm[256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb  = x[7:0];
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3 = k[31:0];
    logic [31:0] r  = {w3[23:0], w3[31:24]};
    logic [31:0] t  = {sbm[r[31:24]] ^ rc, sbm[r[23:16]], sbm[r[15:8]], sbm[r[7:0]]};
    logic [31:0] a  = k[127:96] ^ t;
    logic [31:0] b  = k[95:64] ^ a;
    logic [31:0] c  = k[63:32] ^ b;
    logic [31:0] d  = w3 ^ c;
    return {a, b, c, d};
  endfunction

  task automatic push_stream(input logic [127:0] k);
    logic [127:0] cur = k;
    logic [7:0]   rc  = 8'h01;
    for (int r = 0; r <= 10; r++) begin
      exp_t e;
      e.round = r[3:0];
      e.data  = cur;
      exp_q.push_back(e);
      if (r < 10) begin
        cur = model_next(cur, rc);
        rc  = gmul(rc, 8'h02);
      end
    end
  endtask

  // Drives one full stream starting at the current negedge. stall adds alternate and burst
  // rk_ready stalls; inj_round fires a second start while that round is presented; b2b leaves
  // the bench in the done cycle so the caller can start again immediately.
  task automatic run_stream(input logic [127:0] k, input bit stall, input int inj_round, input bit b2b);
    int           cyc = 1;
    int           stalls = 0;
    int           burst = 0;
    bit           finished = 0;
    bit           held_vld = 0;
    bit           injected = 0;
    bit           rdy;
    logic [127:0] held_dat = '0;
    logic [3:0]   held_rnd = '0;
    exp_t         e;

    chk("idle_valid", bus.rk_valid, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    bus.start = 1'b1;
    bus.key   = k;
    push_stream(k);
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = {$urandom, $urandom, $urandom, $urandom};

    while (!finished && cyc < 200) begin
      chk("emit_valid", bus.rk_valid, 1'b1);
      chk("emit_done_low", bus.done, 1'b0);
      if (held_vld) begin
        chk("stall_hold_data", bus.rk_data, held_dat);
        chk("stall_hold_round", bus.rk_round, held_rnd);
      end
      bus.start = 1'b0;
      if (bus.rk_round == inj_round && !injected) begin
        bus.start = 1'b1;
        bus.key   = ~k;
        injected  = 1;
      end
      if (!stall) rdy = 1;
      else if (burst > 0) begin rdy = 0; burst--; end
      else if (cyc % 2 == 0) rdy = 0;
      else if ($urandom_range(0, 5) == 0) begin rdy = 0; burst = $urandom_range(0, 4); end
      else rdy = 1;
      bus.rk_ready = rdy;
      if (rdy) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_underflow: transfer with round %0d but nothing expected", bus.rk_round);
          finished = 1;
        end else begin
          e = exp_q.pop_front();
          chk("rk_data", bus.rk_data, e.data);
          chk("rk_round", bus.rk_round, e.round);
          cap[e.round] = bus.rk_data;
          if (e.round == 4'd10) finished = 1;
        end
        held_vld = 0;
      end else begin
        stalls++;
        held_dat = bus.rk_data;
        held_rnd = bus.rk_round;
        held_vld = 1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end

    if (!finished) begin
      errors++; checks++;
      $display("FAIL stream_timeout: cycles=%0d required round 10 transfer", cyc);
    end
    bus.rk_ready = 1'($urandom);
    chk("done_pulse", bus.done, 1'b1);
    chk("done_busy_low", bus.busy, 1'b0);
    chk("done_valid_low", bus.rk_valid, 1'b0);
    chk("done_cycle", cyc, 12 + stalls);
    chk("queue_empty", exp_q.size(), 0);
    if (!b2b) begin
      @(negedge clk);
      chk("done_single_pulse", bus.done, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    bit   found;

    vecs[0] = '{"a1_r0",   KEY_A1,   0,  KEY_A1};
    vecs[1] = '{"a1_r1",   KEY_A1,   1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{"a1_r2",   KEY_A1,   2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{"a1_r10",  KEY_A1,   10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{"zero_r1", KEY_ZERO, 1,  128'h62636363626363636263636362636363};
    vecs[5] = '{"zero_r10", KEY_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.rk_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_valid", bus.rk_valid, 1'b0);
    chk("rst_data", bus.rk_data, 128'h0);
    chk("rst_round", bus.rk_round, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Known-answer vectors, each from a fresh full-rate stream.
    for (int i = 0; i < 6; i++) begin
      run_stream(vecs[i].key, 1'b0, -1, 1'b0);
      chk(vecs[i].name, cap[vecs[i].idx], vecs[i].expect_rk);
    end

    // Backpressure: alternate and burst stalls, same keys.
    run_stream(KEY_A1, 1'b1, -1, 1'b0);
    chk("bp_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Second start with another key during round 4 must be ignored.
    run_stream(KEY_A1, 1'b0, 4, 1'b0);
    chk("busy_start_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset during round 6 aborts asynchronously.
    bus.start = 1'b1;
    bus.key   = KEY_A1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rk_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.rk_round == 4'd6 && bus.rk_valid) found = 1;
      else @(negedge clk);
    end
    chk("rst_reached_r6", found, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", bus.rk_valid, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_round", bus.rk_round, 4'd0);
    chk("abort_data", bus.rk_data, 128'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.rk_ready = 1'b0;
    @(negedge clk);
    chk("abort_no_done", bus.done, 1'b0);
    run_stream(KEY_A1, 1'b0, -1, 1'b0);
    chk("restart_r0", cap[0], KEY_A1);

    // Start in the done cycle is accepted immediately.
    run_stream(KEY_A1, 1'b0, -1, 1'b1);
    run_stream(KEY_ZERO, 1'b0, -1, 1'b0);
    chk("b2b_zero_r1", cap[1], 128'h62636363626363636263636362636363);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
